// File: rtl/mantle_set_idx_reg_array_pkg.sv
// Shared types for the indexed register array: command opcodes and controller states.
package mantle_set_idx_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_COPY  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COPY  = 2'b01,
    S_CLEAR = 2'b10
  } state_e;

endpackage

// File: rtl/mantle_set_idx_reg_array_if.sv
// Command/completion bus of the indexed register array.
interface mantle_set_idx_reg_array_if #(
  parameter  int N     = 9,
  parameter  int W     = 32,
  localparam int IDX_W = $clog2(N)
) ();

  logic                      cmd_valid;
  logic                      cmd_ready;
  mantle_set_idx_pkg::op_e   cmd_op;
  logic [IDX_W-1:0]          cmd_idx;
  logic [IDX_W-1:0]          cmd_src;
  logic [W-1:0]              cmd_val;
  logic                      done;
  logic                      err;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_src, cmd_val,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_src, cmd_val,
    output cmd_ready, done, err
  );

endinterface

// File: rtl/mantle_set_idx_reg_array_reg.sv
// W-bit storage register with load enable and asynchronous active-low clear.
module mantle_reg_arst_en #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mantle_set_idx_reg_array.sv
// N-entry register array with SET / COPY / CLEAR commands sharing one write port.
module mantle_set_idx_reg_array
  import mantle_set_idx_pkg::*;
#(
  parameter  int N     = 9,
  parameter  int W     = 32,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                        CLK,
  input  logic                        ASYNCRESETN,
  mantle_set_idx_reg_array_if.slave   cmd,
  output logic [W-1:0]                O [N]
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             idx_oor, src_oor;
  logic [W-1:0]     src_val;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [W-1:0]     wr_data;
  logic [N-1:0]     en;

  assign cmd.cmd_ready = ASYNCRESETN && (state_q == S_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign idx_oor       = int'(cmd.cmd_idx) >= N;
  assign src_oor       = int'(cmd.cmd_src) >= N;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;

  // Explicit mux keeps an out-of-range source from ever indexing past the array.
  always_comb begin
    src_val = '0;
    for (int i = 0; i < N; i++)
      if (cmd.cmd_src == IDX_W'(i)) src_val = O[i];
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cmd.cmd_idx;
    wr_data = cmd.cmd_val;
    unique case (state_q)
      S_IDLE: if (accept) begin
        case (cmd.cmd_op)
          OP_NOP: done_d = 1'b1;
          OP_SET: begin
            if (idx_oor) err_d = 1'b1;
            else begin
              wr_en  = 1'b1;
              done_d = 1'b1;
            end
          end
          OP_COPY: begin
            if (idx_oor || src_oor) err_d = 1'b1;
            else begin
              hold_d  = src_val;
              dst_d   = cmd.cmd_idx;
              state_d = S_COPY;
            end
          end
          OP_CLEAR: begin
            cnt_d   = '0;
            state_d = S_CLEAR;
          end
          default: ;
        endcase
      end
      S_COPY: begin
        wr_en   = 1'b1;
        wr_idx  = dst_q;
        wr_data = hold_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = '0;
        // Counter parks on the last entry so a non-power-of-two N never wraps.
        if (cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ent
    assign en[i] = wr_en && (wr_idx == IDX_W'(i));
    mantle_reg_arst_en #(.W(W)) u_ent (
      .clk   (CLK),
      .rst_n (ASYNCRESETN),
      .en    (en[i]),
      .d     (wr_data),
      .q     (O[i])
    );
  end

endmodule

// File: tb/tb_mantle_set_idx_reg_array.sv
// Directed bench for mantle_set_idx_reg_array at N=9, W=32.
module tb_mantle_set_idx_reg_array;
  import mantle_set_idx_pkg::*;

  localparam int N = 9;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] o [N];
  int           n_run  = 0;
  int           n_fail = 0;

  mantle_set_idx_reg_array_if #(.N(N), .W(W)) bus ();

  mantle_set_idx_reg_array #(.N(N), .W(W)) dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .cmd         (bus),
    .O           (o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [3:0] idx, input logic [3:0] src,
                       input logic [W-1:0] val);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx;
    bus.cmd_src   = src;
    bus.cmd_val   = val;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_idx   = '0;
    bus.cmd_src   = '0;
    bus.cmd_val   = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("rst_o%0d", i), o[i], 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk("rel_ready", bus.cmd_ready, 1);

    // SET idx 7
    issue(OP_SET, 4'd7, 4'd0, 32'hDEADBEEF);
    chk("set_o7", o[7], 32'hDEADBEEF);
    chk("set_o6", o[6], 0);
    chk("set_o8", o[8], 0);
    chk("set_done", bus.done, 1);
    chk("set_err", bus.err, 0);
    tick();
    chk("set_done_off", bus.done, 0);

    // COPY 3 -> 7
    issue(OP_SET, 4'd3, 4'd0, 32'h12345678);
    issue(OP_COPY, 4'd7, 4'd3, 32'hFFFFFFFF);
    chk("cp_ready_lo", bus.cmd_ready, 0);
    chk("cp_done_lo", bus.done, 0);
    chk("cp_o7_old", o[7], 32'hDEADBEEF);
    tick();
    chk("cp_o7", o[7], 32'h12345678);
    chk("cp_done", bus.done, 1);
    chk("cp_ready_hi", bus.cmd_ready, 1);
    chk("cp_o3", o[3], 32'h12345678);
    tick();
    chk("cp_done_off", bus.done, 0);

    // COPY onto itself
    issue(OP_COPY, 4'd3, 4'd3, 32'h0);
    tick();
    chk("cps_o3", o[3], 32'h12345678);
    chk("cps_done", bus.done, 1);

    // Back-to-back fill, then CLEAR sweep
    for (int i = 0; i < N; i++)
      issue(OP_SET, 4'(i), 4'd0, 32'h1000_0000 + 32'(i) * 32'h111);
    for (int i = 0; i < N; i++)
      chk($sformatf("fill_o%0d", i), o[i], 32'h1000_0000 + 32'(i) * 32'h111);
    issue(OP_CLEAR, 4'd15, 4'd15, 32'h0);
    chk("clr_ready0", bus.cmd_ready, 0);
    chk("clr_o0_kept", o[0], 32'h1000_0000);
    for (int k = 0; k < N; k++) begin
      tick();
      chk($sformatf("clr_o%0d", k), o[k], 0);
      if (k < N - 1)
        chk($sformatf("clr_next%0d", k + 1), o[k + 1], 32'h1000_0000 + 32'(k + 1) * 32'h111);
      chk($sformatf("clr_done%0d", k), bus.done, (k == N - 1) ? 1 : 0);
      chk($sformatf("clr_ready%0d", k), bus.cmd_ready, (k == N - 1) ? 1 : 0);
    end
    tick();
    chk("clr_done_off", bus.done, 0);

    // Out-of-range commands
    issue(OP_SET, 4'd2, 4'd0, 32'hAAAA5555);
    issue(OP_SET, 4'd9, 4'd0, 32'h55555555);
    chk("oor_set_err", bus.err, 1);
    chk("oor_set_done", bus.done, 0);
    chk("oor_set_o2", o[2], 32'hAAAA5555);
    chk("oor_set_o0", o[0], 0);
    tick();
    chk("oor_err_off", bus.err, 0);
    issue(OP_COPY, 4'd0, 4'd12, 32'h0);
    chk("oor_cp_err", bus.err, 1);
    chk("oor_cp_done", bus.done, 0);
    chk("oor_cp_ready", bus.cmd_ready, 1);
    chk("oor_cp_o0", o[0], 0);
    issue(OP_COPY, 4'd13, 4'd2, 32'h0);
    chk("oor_dst_err", bus.err, 1);
    chk("oor_dst_done", bus.done, 0);
    issue(OP_NOP, 4'd15, 4'd15, 32'h0);
    chk("nop_done", bus.done, 1);
    chk("nop_err", bus.err, 0);
    chk("nop_o2", o[2], 32'hAAAA5555);

    // Reset in the middle of a CLEAR sweep
    issue(OP_SET, 4'd4, 4'd0, 32'hCAFEF00D);
    issue(OP_SET, 4'd8, 4'd0, 32'h0BADC0DE);
    issue(OP_CLEAR, 4'd0, 4'd0, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("mid_o4_kept", o[4], 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_o4", o[4], 0);
    chk("mid_o8", o[8], 0);
    chk("mid_o2", o[2], 0);
    chk("mid_ready", bus.cmd_ready, 0);
    chk("mid_done", bus.done, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", bus.cmd_ready, 1);
    chk("mid_rel_done", bus.done, 0);
    tick();
    chk("mid_after_done", bus.done, 0);
    chk("mid_after_err", bus.err, 0);
    chk("mid_after_o8", o[8], 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
